// File: rtl/axi4lite_pkg.sv
// ---------------------------------------------------------------------------
// axi4lite_pkg
// Shared definitions for AXI4-Lite slaves: response codes, write/read FSM
// state types and a byte-strobe merge helper.
// strb_merge works on the widest supported data word (64 bits); callers
// zero-extend narrower words and truncate the result.
// ---------------------------------------------------------------------------
package axi4lite_pkg;

    localparam int MAX_DATA_W = 64;
    localparam int MAX_STRB_W = MAX_DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } r_state_e;

    // Byte j of the result comes from new_val when strb[j] is set, else old_val.
    function automatic logic [MAX_DATA_W-1:0] strb_merge(
        input logic [MAX_DATA_W-1:0] old_val,
        input logic [MAX_DATA_W-1:0] new_val,
        input logic [MAX_STRB_W-1:0] strb
    );
        logic [MAX_DATA_W-1:0] res;
        res = old_val;
        for (int j = 0; j < MAX_STRB_W; j++) begin
            if (strb[j]) begin
                res[j*8 +: 8] = new_val[j*8 +: 8];
            end else begin
                res[j*8 +: 8] = old_val[j*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axi4lite_wr_join.sv
// ---------------------------------------------------------------------------
// axi4lite_wr_join
// Joins the independent AW and W channels of an AXI4-Lite slave. Whichever
// channel arrives first is parked in a holding register until the other
// shows up; commit is asserted for the cycle whose clock edge completes the
// pair, with the joined address/data/strobe presented alongside.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   aw_addr/valid/ready  write-address channel
//   w_data/strb/valid/ready write-data channel
//   resp_busy            write response outstanding (blocks both channels)
//   commit               both halves present on this edge
//   commit_addr/data/strb joined write, valid while commit is high
// ---------------------------------------------------------------------------
module axi4lite_wr_join #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   aw_addr,
    input  logic                    aw_valid,
    output logic                    aw_ready,
    input  logic [DATA_WIDTH-1:0]   w_data,
    input  logic [DATA_WIDTH/8-1:0] w_strb,
    input  logic                    w_valid,
    output logic                    w_ready,
    input  logic                    resp_busy,
    output logic                    commit,
    output logic [ADDR_WIDTH-1:0]   commit_addr,
    output logic [DATA_WIDTH-1:0]   commit_data,
    output logic [DATA_WIDTH/8-1:0] commit_strb
);

    logic                    aw_held_r;
    logic                    w_held_r;
    logic [ADDR_WIDTH-1:0]   addr_r;
    logic [DATA_WIDTH-1:0]   data_r;
    logic [DATA_WIDTH/8-1:0] strb_r;
    logic                    aw_hs_s;
    logic                    w_hs_s;

    assign aw_ready = !aw_held_r && !resp_busy;
    assign w_ready  = !w_held_r && !resp_busy;
    assign aw_hs_s  = aw_valid && aw_ready;
    assign w_hs_s   = w_valid && w_ready;

    assign commit      = (aw_held_r || aw_hs_s) && (w_held_r || w_hs_s);
    assign commit_addr = aw_held_r ? addr_r : aw_addr;
    assign commit_data = w_held_r ? data_r : w_data;
    assign commit_strb = w_held_r ? strb_r : w_strb;

    // Holding registers: park a lone channel, release both on commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            aw_held_r <= 1'b0;
            w_held_r  <= 1'b0;
            addr_r    <= '0;
            data_r    <= '0;
            strb_r    <= '0;
        end else if (commit) begin
            aw_held_r <= 1'b0;
            w_held_r  <= 1'b0;
        end else begin
            if (aw_hs_s) begin
                aw_held_r <= 1'b1;
                addr_r    <= aw_addr;
            end
            if (w_hs_s) begin
                w_held_r <= 1'b1;
                data_r   <= w_data;
                strb_r   <= w_strb;
            end
        end
    end

endmodule

// File: rtl/axi4lite_reg_bank.sv
// ---------------------------------------------------------------------------
// axi4lite_reg_bank
// AXI4-Lite slave exposing NUM_REGS control/status registers. RW registers
// are byte-strobe writable; registers flagged in RO_MASK return ro_data_i
// (sampled on the AR handshake) and reject writes with SLVERR. Addresses
// outside the window answer DECERR with zero read data.
// Ports:
//   aclk, reset          clock, synchronous active-high reset
//   s_axi_aw*/w*/b*      AXI4-Lite write channels (prot ignored)
//   s_axi_ar*/r*         AXI4-Lite read channels (prot ignored)
//   regs_o               stored register values, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//   wr_stb_o             one-cycle pulse per committed RW register write
//   ro_data_i            sources for read-only registers
// ---------------------------------------------------------------------------
module axi4lite_reg_bank
    import axi4lite_pkg::*;
#(
    parameter int                         ADDR_WIDTH = 32,
    parameter int                         DATA_WIDTH = 32,
    parameter int                         NUM_REGS   = 16,
    parameter logic [ADDR_WIDTH-1:0]      BASE_ADDR  = '0,
    parameter logic [NUM_REGS-1:0]        RO_MASK    = '0,
    parameter logic [DATA_WIDTH-1:0]      RESET_VAL  = '0
) (
    input  logic                           aclk,
    input  logic                           reset,
    input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
    input  logic [2:0]                     s_axi_awprot,
    input  logic                           s_axi_awvalid,
    output logic                           s_axi_awready,
    input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
    input  logic                           s_axi_wvalid,
    output logic                           s_axi_wready,
    output logic [1:0]                     s_axi_bresp,
    output logic                           s_axi_bvalid,
    input  logic                           s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
    input  logic [2:0]                     s_axi_arprot,
    input  logic                           s_axi_arvalid,
    output logic                           s_axi_arready,
    output logic [DATA_WIDTH-1:0]          s_axi_rdata,
    output logic [1:0]                     s_axi_rresp,
    output logic                           s_axi_rvalid,
    input  logic                           s_axi_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-1:0]            wr_stb_o,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_data_i
);

    localparam int BYTES    = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(BYTES);
    localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(NUM_REGS * BYTES);

    // Wrapping subtraction: addresses below BASE_ADDR become huge offsets.
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        return (addr - BASE_ADDR) < SPAN;
    endfunction

    function automatic logic [IDX_W-1:0] reg_idx(input logic [ADDR_WIDTH-1:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> ADDR_LSB);
    endfunction

    logic [DATA_WIDTH-1:0]   regs_r [NUM_REGS];
    logic [NUM_REGS-1:0]     wr_stb_r;
    w_state_e                w_state_r, w_state_s;
    r_state_e                r_state_r, r_state_s;
    logic [1:0]              bresp_r, rresp_r;
    logic [DATA_WIDTH-1:0]   rdata_r;

    logic                    commit_s;
    logic [ADDR_WIDTH-1:0]   c_addr_s;
    logic [DATA_WIDTH-1:0]   c_data_s;
    logic [DATA_WIDTH/8-1:0] c_strb_s;
    logic                    wr_in_range_s, wr_ro_s;
    logic [IDX_W-1:0]        wr_idx_s;
    logic [1:0]              wr_resp_s;
    logic [NUM_REGS-1:0]     wr_en_s;

    logic                    ar_hs_s, rd_in_range_s;
    logic [IDX_W-1:0]        rd_idx_s;
    logic [DATA_WIDTH-1:0]   rd_data_s;
    logic [1:0]              rd_resp_s;
    logic                    unused_s;

    assign unused_s = ^{s_axi_awprot, s_axi_arprot};

    axi4lite_wr_join #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_wr_join (
        .clk        (aclk),
        .reset      (reset),
        .aw_addr    (s_axi_awaddr),
        .aw_valid   (s_axi_awvalid),
        .aw_ready   (s_axi_awready),
        .w_data     (s_axi_wdata),
        .w_strb     (s_axi_wstrb),
        .w_valid    (s_axi_wvalid),
        .w_ready    (s_axi_wready),
        .resp_busy  (s_axi_bvalid),
        .commit     (commit_s),
        .commit_addr(c_addr_s),
        .commit_data(c_data_s),
        .commit_strb(c_strb_s)
    );

    // Write decode: classify the joined write and build per-register enables.
    always_comb begin
        wr_in_range_s = in_range(c_addr_s);
        wr_idx_s      = reg_idx(c_addr_s);
        wr_ro_s       = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_ro_s = wr_ro_s | (RO_MASK[i] & (wr_idx_s == IDX_W'(i)));
        end
        if (!wr_in_range_s) begin
            wr_resp_s = RESP_DECERR;
        end else if (wr_ro_s) begin
            wr_resp_s = RESP_SLVERR;
        end else begin
            wr_resp_s = RESP_OKAY;
        end
        wr_en_s = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_en_s[i] = commit_s && wr_in_range_s && !wr_ro_s && (wr_idx_s == IDX_W'(i));
        end
    end

    // Register array and write strobes.
    always_ff @(posedge aclk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= RESET_VAL;
            end
            wr_stb_r <= '0;
        end else begin
            wr_stb_r <= wr_en_s;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en_s[i]) begin
                    regs_r[i] <= DATA_WIDTH'(strb_merge(MAX_DATA_W'(regs_r[i]),
                                                        MAX_DATA_W'(c_data_s),
                                                        MAX_STRB_W'(c_strb_s)));
                end
            end
        end
    end

    // Write FSM next state.
    always_comb begin
        w_state_s = w_state_r;
        case (w_state_r)
            W_IDLE:  w_state_s = commit_s ? W_RESP : W_IDLE;
            W_RESP:  w_state_s = s_axi_bready ? W_IDLE : W_RESP;
            default: w_state_s = W_IDLE;
        endcase
    end

    // Write FSM state and response capture.
    always_ff @(posedge aclk) begin
        if (reset) begin
            w_state_r <= W_IDLE;
            bresp_r   <= RESP_OKAY;
        end else begin
            w_state_r <= w_state_s;
            if (commit_s) begin
                bresp_r <= wr_resp_s;
            end
        end
    end

    // Read decode: RO registers read the live input, RW the stored value.
    always_comb begin
        rd_in_range_s = in_range(s_axi_araddr);
        rd_idx_s      = reg_idx(s_axi_araddr);
        rd_data_s     = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx_s == IDX_W'(i)) begin
                rd_data_s = RO_MASK[i] ? ro_data_i[i*DATA_WIDTH +: DATA_WIDTH] : regs_r[i];
            end else begin
                rd_data_s = rd_data_s;
            end
        end
        if (rd_in_range_s) begin
            rd_resp_s = RESP_OKAY;
        end else begin
            rd_data_s = '0;
            rd_resp_s = RESP_DECERR;
        end
    end

    assign ar_hs_s = s_axi_arvalid && s_axi_arready;

    // Read FSM next state.
    always_comb begin
        r_state_s = r_state_r;
        case (r_state_r)
            R_IDLE:  r_state_s = ar_hs_s ? R_RESP : R_IDLE;
            R_RESP:  r_state_s = s_axi_rready ? R_IDLE : R_RESP;
            default: r_state_s = R_IDLE;
        endcase
    end

    // Read FSM state and response capture (held until rready).
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_state_r <= R_IDLE;
            rdata_r   <= '0;
            rresp_r   <= RESP_OKAY;
        end else begin
            r_state_r <= r_state_s;
            if (ar_hs_s) begin
                rdata_r <= rd_data_s;
                rresp_r <= rd_resp_s;
            end
        end
    end

    assign s_axi_bvalid  = (w_state_r == W_RESP);
    assign s_axi_bresp   = bresp_r;
    assign s_axi_arready = (r_state_r == R_IDLE);
    assign s_axi_rvalid  = (r_state_r == R_RESP);
    assign s_axi_rdata   = rdata_r;
    assign s_axi_rresp   = rresp_r;
    assign wr_stb_o      = wr_stb_r;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs_out
        assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = regs_r[g];
    end

endmodule
